// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int WORD_SHIFT = $clog2(WORD_BYTES);

  // Bit positions inside the latched error-cause vector.
  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;
  localparam int ERR_CONFLICT = 2;
  localparam int ERR_W        = 3;

endpackage

// File: rtl/sp_ram.sv
// Single-port word RAM with registered read data.
// Latency: rdata valid the cycle after re; write lands on the same edge as we.
// Backpressure: none; the caller sequences accesses.
module sp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Serves MEM-stage loads/stores from a word RAM, flagging bad requests.
// Latency: ready pulses WAIT_CYCLES+1 cycles after a request is first seen in IDLE.
// Backpressure: stall is held to the pipeline from accept until the DONE cycle.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_En,
  input  logic              write_En,
  input  logic [31:0]       DataAddress,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              ready,
  output logic              err,
  output logic              stall
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              req, idle, accepting, enter_done;

  logic [ERR_W-1:0]  err_in, err_lat, err_cur;
  logic              op_rd_lat, op_wr_lat, op_rd_cur, op_wr_cur;
  logic [ADDR_W-1:0] waddr_in, waddr_lat, ram_addr;
  logic [DATA_W-1:0] wdata_lat, ram_wdata, ram_rdata;
  logic              ram_we, ram_re, rd_zero;

  assign req       = read_En | write_En;
  assign idle      = (state == IDLE);
  assign accepting = idle && req;

  assign err_in[ERR_MISALIGN] = (DataAddress[WORD_SHIFT-1:0] != '0);
  assign err_in[ERR_RANGE]    = (DataAddress[31:ADDR_W+WORD_SHIFT] != '0);
  assign err_in[ERR_CONFLICT] = read_En & write_En;
  assign waddr_in             = DataAddress[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];

  // With zero wait states the RAM access happens on the accept edge itself,
  // so the live request must feed the RAM before it has been latched.
  assign err_cur   = idle ? err_in    : err_lat;
  assign op_rd_cur = idle ? read_En   : op_rd_lat;
  assign op_wr_cur = idle ? write_En  : op_wr_lat;
  assign ram_addr  = idle ? waddr_in  : waddr_lat;
  assign ram_wdata = idle ? WriteData : wdata_lat;

  assign enter_done = (state_nxt == DONE) && !reset;
  assign ram_we     = enter_done && op_wr_cur && (err_cur == '0);
  assign ram_re     = enter_done && op_rd_cur && (err_cur == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req) state_nxt = (WAIT_CYCLES == 0) ? DONE : BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall = accepting || (state == BUSY);
    ready = (state == DONE);
    err   = (state == DONE) && (err_lat != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 4'd0;
      err_lat   <= '0;
      op_rd_lat <= 1'b0;
      op_wr_lat <= 1'b0;
      waddr_lat <= '0;
      wdata_lat <= '0;
    end else if (accepting) begin
      cnt       <= CNT_INIT;
      err_lat   <= err_in;
      op_rd_lat <= read_En;
      op_wr_lat <= write_En;
      waddr_lat <= waddr_in;
      wdata_lat <= WriteData;
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Clean stores leave the last load result visible; loads and rejects replace it.
  always_ff @(posedge clk) begin
    if (reset) rd_zero <= 1'b1;
    else if (enter_done && (op_rd_cur || err_cur != '0)) rd_zero <= (err_cur != '0);
  end

  assign ReadData = rd_zero ? '0 : ram_rdata;

  sp_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance 1 runs with two wait states, instance 0 with none.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rd, wr, rdy, er, stl;
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] rdat [2];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .read_En(rd[0]), .write_En(wr[0]),
    .DataAddress(addr[0]), .WriteData(wd[0]), .ReadData(rdat[0]),
    .ready(rdy[0]), .err(er[0]), .stall(stl[0])
  );

  data_mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset), .read_En(rd[1]), .write_En(wr[1]),
    .DataAddress(addr[1]), .WriteData(wd[1]), .ReadData(rdat[1]),
    .ready(rdy[1]), .err(er[1]), .stall(stl[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Presents a request at a falling edge and holds it until the ready cycle.
  task automatic do_access(input int u, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rdata, output logic e,
                           output int lat, output int stalls, output int start);
    logic got;
    @(negedge clk);
    rd[u] = r; wr[u] = w; addr[u] = a; wd[u] = d;
    start = cyc; lat = 0; stalls = 0; rdata = '0; e = 1'b0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (stl[u]) stalls++;
      if (rdy[u]) begin
        got = 1'b1; rdata = rdat[u]; e = er[u];
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    if (!got) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic go_idle(input int u, input string tag);
    @(negedge clk);
    rd[u] = 1'b0; wr[u] = 1'b0;
    #1;
    chk({tag, "_idle_stall"}, {31'd0, stl[u]}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, rdy[u]}, 32'd0);
  endtask

  logic [31:0] d;
  logic        e;
  int          lat, stalls, s0, s1;

  initial begin
    reset = 1'b1; rd = '0; wr = '0;
    addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("rst_rdata", rdat[u], 32'd0);
      chk("rst_ready", {31'd0, rdy[u]}, 32'd0);
      chk("rst_err",   {31'd0, er[u]},  32'd0);
      chk("rst_stall", {31'd0, stl[u]}, 32'd0);
    end
    reset = 1'b0;

    // Two wait states: store then load the same word.
    do_access(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, d, e, lat, stalls, s0);
    chk("t1_wr_lat", lat, 3);
    chk("t1_wr_stalls", stalls, 3);
    chk("t1_wr_err", {31'd0, e}, 32'd0);
    do_access(1, 1'b1, 1'b0, 32'h10, 32'h0, d, e, lat, stalls, s0);
    chk("t1_rd_lat", lat, 3);
    chk("t1_rd_stalls", stalls, 3);
    chk("t1_rd_data", d, 32'hDEADBEEF);
    chk("t1_rd_err", {31'd0, e}, 32'd0);
    go_idle(1, "t1");

    // Zero wait states: load then store back-to-back.
    do_access(0, 1'b0, 1'b1, 32'h8, 32'h11112222, d, e, lat, stalls, s0);
    chk("t2_setup_lat", lat, 1);
    do_access(0, 1'b1, 1'b0, 32'h8, 32'h0, d, e, lat, stalls, s0);
    chk("t2_rd_lat", lat, 1);
    chk("t2_rd_stalls", stalls, 1);
    chk("t2_rd_data", d, 32'h11112222);
    do_access(0, 1'b0, 1'b1, 32'h8, 32'h33334444, d, e, lat, stalls, s1);
    chk("t2_wr_lat", lat, 1);
    chk("t2_accept_gap", s1 - s0, 2);
    chk("t2_wr_err", {31'd0, e}, 32'd0);
    do_access(0, 1'b1, 1'b0, 32'h8, 32'h0, d, e, lat, stalls, s0);
    chk("t2_rb_data", d, 32'h33334444);
    go_idle(0, "t2");

    // Misaligned load.
    do_access(1, 1'b1, 1'b0, 32'h13, 32'h0, d, e, lat, stalls, s0);
    chk("t3_err", {31'd0, e}, 32'd1);
    chk("t3_rdata", d, 32'd0);
    chk("t3_lat", lat, 3);
    chk("t3_stalls", stalls, 3);
    go_idle(1, "t3");

    // Out-of-range store must not alias onto word 0.
    do_access(1, 1'b0, 1'b1, 32'h0, 32'hCAFEF00D, d, e, lat, stalls, s0);
    do_access(1, 1'b0, 1'b1, 32'h400, 32'h55, d, e, lat, stalls, s0);
    chk("t4_err", {31'd0, e}, 32'd1);
    do_access(1, 1'b1, 1'b0, 32'h0, 32'h0, d, e, lat, stalls, s0);
    chk("t4_rd_data", d, 32'hCAFEF00D);
    chk("t4_rd_err", {31'd0, e}, 32'd0);

    // Conflicting read+write.
    do_access(1, 1'b0, 1'b1, 32'h20, 32'h0BADC0DE, d, e, lat, stalls, s0);
    do_access(1, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, d, e, lat, stalls, s0);
    chk("t5_err", {31'd0, e}, 32'd1);
    chk("t5_rdata", d, 32'd0);
    do_access(1, 1'b1, 1'b0, 32'h20, 32'h0, d, e, lat, stalls, s0);
    chk("t5_rd_data", d, 32'h0BADC0DE);

    // Reset during BUSY drops the pending store.
    do_access(1, 1'b0, 1'b1, 32'h30, 32'h00000777, d, e, lat, stalls, s0);
    @(negedge clk);
    rd[1] = 1'b0; wr[1] = 1'b1; addr[1] = 32'h30; wd[1] = 32'h1234;
    @(negedge clk);
    #1;
    chk("t6_busy_stall", {31'd0, stl[1]}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; wr[1] = 1'b0;
    #1;
    chk("t6_post_rst_stall", {31'd0, stl[1]}, 32'd0);
    chk("t6_post_rst_ready", {31'd0, rdy[1]}, 32'd0);
    chk("t6_post_rst_rdata", rdat[1], 32'd0);
    do_access(1, 1'b1, 1'b0, 32'h30, 32'h0, d, e, lat, stalls, s0);
    chk("t6_rd_data", d, 32'h00000777);
    chk("t6_rd_lat", lat, 3);
    go_idle(1, "t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
